serial_cmp_izq_der: RTL and testbench



---
 rtl/serial_cmp_izq_der.sv | 147 ++++++++++++++
 tb/tb_serial_cmp_izq_der.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_izq_der.sv
// -----------------------------------------------------------------------------
// serial_cmp_izq_der
//   Sequential magnitude comparator for two (N+1)-bit words. It scans one bit
//   per clock, starting at the MSB and moving towards the LSB (left to right).
//   A 2-bit initial comparison state lets this stage sit behind a
//   more-significant stage in a cascade.
//
// Parameters
//   N          MSB index of the compared words (word width = N+1)
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   start      comparison request; sampled only in IDLE
//   palabraA   operand A, captured on the accepted start edge
//   palabraB   operand B, captured on the accepted start edge
//   x_in       initial state: 00 equal, 10 A greater, 01 B greater, 11 as 00
//   busy       high while in SHIFT or DONE
//   done       one-cycle pulse in DONE
//   gt/eq/lt   registered one-hot result, held until the next comparison ends
//   Z          alias of gt
//
// Optional build macro
//   SERIAL_CMP_EARLY_EXIT_EN  leave SHIFT as soon as the outcome is decided.
//                             Results are the same; only latency changes.
// -----------------------------------------------------------------------------
module serial_cmp_izq_der #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N:0]   palabraA,
   input  logic [N:0]   palabraB,
   input  logic [1:0]   x_in,
   output logic         busy,
   output logic         done,
   output logic         gt,
   output logic         eq,
   output logic         lt,
   output logic         Z
);

   // Counter width: clog2(N+1), never below one bit.
   localparam int unsigned CW = ((N + 1) > 1) ? $clog2(N + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Running comparison state encodings.
   localparam logic [1:0] X_EQ = 2'b00;
   localparam logic [1:0] X_GT = 2'b10;
   localparam logic [1:0] X_LT = 2'b01;

   state_t        state;
   logic [N:0]    reg_a;
   logic [N:0]    reg_b;
   logic [1:0]    x;
   logic [CW-1:0] cnt;

   logic [1:0]    x_next;
   logic          scan_exit;

   // Next comparison state from the current MSBs. Once decided, x is frozen,
   // so the first differing bit (scanning from the left) wins.
   always_comb begin
      x_next = x;
      if (x == X_EQ) begin
         if (reg_a[N] && !reg_b[N]) begin
            x_next = X_GT;
         end else if (!reg_a[N] && reg_b[N]) begin
            x_next = X_LT;
         end
      end
   end

   // cnt == 0 means this edge handles bit 0, the last one.
   always_comb begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      scan_exit = (cnt == '0) || (x_next != X_EQ);
`else
      scan_exit = (cnt == '0);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         reg_a <= '0;
         reg_b <= '0;
         x     <= X_EQ;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         gt    <= 1'b0;
         eq    <= 1'b1;
         lt    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  reg_a <= palabraA;
                  reg_b <= palabraB;
                  // 11 from the cascade is meaningless and means "equal".
                  x     <= (x_in == 2'b11) ? X_EQ : x_in;
                  cnt   <= CW'(N);
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               x     <= x_next;
               reg_a <= reg_a << 1;
               reg_b <= reg_b << 1;
               cnt   <= cnt - 1'b1;
               if (scan_exit) begin
                  gt    <= (x_next == X_GT);
                  lt    <= (x_next == X_LT);
                  eq    <= (x_next == X_EQ);
                  done  <= 1'b1;
                  state <= DONE;
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign Z = gt;

endmodule

// File: tb/tb_serial_cmp_izq_der.sv
// -----------------------------------------------------------------------------
// tb_serial_cmp_izq_der
//   Scoreboard bench. The driver pushes the expected result and latency for
//   every accepted start. A monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_cmp_izq_der;

   localparam int unsigned N = 4;

   logic         clk;
   logic         reset;
   logic         start;
   logic [N:0]   palabraA;
   logic [N:0]   palabraB;
   logic [1:0]   x_in;
   logic         busy;
   logic         done;
   logic         gt;
   logic         eq;
   logic         lt;
   logic         Z;

   serial_cmp_izq_der #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .palabraA (palabraA),
      .palabraB (palabraB),
      .x_in     (x_in),
      .busy     (busy),
      .done     (done),
      .gt       (gt),
      .eq       (eq),
      .lt       (lt),
      .Z        (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result encoding {gt, eq, lt, Z}
   localparam logic [3:0] R_GT = 4'b1001;
   localparam logic [3:0] R_EQ = 4'b0100;
   localparam logic [3:0] R_LT = 4'b0010;

   typedef struct {
      logic [3:0] res;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected latency for the current build.
   function automatic int lat_sel(input int full, input int early);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      return early;
`else
      return full;
`endif
   endfunction

   // Monitor: lat counts rising edges since the accepted start edge.
   initial begin : monitor
      logic busy_q;
      int   lat;
      exp_t e;
      busy_q = 1'b0;
      lat    = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_q = 1'b0;
         end else begin
            if (busy && !busy_q) lat = 0;
            else if (busy) lat++;
            busy_q = busy;
            if (done) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("result", {28'd0, gt, eq, lt, Z}, {28'd0, e.res});
                  chk("latency", lat, e.lat);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int k;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) break;
      end
      chk("idle_timeout", (k < 40), 1);
   endtask

   task automatic issue(input logic [N:0] a, input logic [N:0] b, input logic [1:0] xi,
                        input logic [3:0] res, input int lat);
      exp_t e;
      @(negedge clk);
      palabraA = a;
      palabraB = b;
      x_in     = xi;
      start    = 1'b1;
      e.res    = res;
      e.lat    = lat;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin : driver
      reset    = 1'b1;
      start    = 1'b0;
      palabraA = '0;
      palabraB = '0;
      x_in     = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_res", {gt, eq, lt, Z}, R_EQ);
      @(negedge clk);
      reset = 1'b0;

      // Difference at bit 2
      issue(5'b10110, 5'b10011, 2'b00, R_GT, lat_sel(5, 3));
      wait_idle();
      // Equal words
      issue(5'b01101, 5'b01101, 2'b00, R_EQ, lat_sel(5, 5));
      wait_idle();
      // Difference at the MSB
      issue(5'b00000, 5'b10000, 2'b00, R_LT, lat_sel(5, 1));
      wait_idle();
      // Cascade input dominates
      issue(5'b11111, 5'b00000, 2'b01, R_LT, lat_sel(5, 1));
      wait_idle();
      // x_in = 11 is treated as equal
      issue(5'b10101, 5'b10101, 2'b11, R_EQ, lat_sel(5, 5));
      wait_idle();

      // Start pulsed during SHIFT must be ignored
      issue(5'b10110, 5'b10011, 2'b00, R_GT, lat_sel(5, 3));
      @(negedge clk);
      palabraA = 5'b00000;
      palabraB = 5'b11111;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_idle();
      issue(5'b00000, 5'b11111, 2'b00, R_LT, lat_sel(5, 1));
      wait_idle();

      // Reset two cycles into a SHIFT; no result may appear
      @(negedge clk);
      palabraA = 5'b00001;
      palabraB = 5'b00010;
      x_in     = 2'b00;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_res", {gt, eq, lt, Z}, R_EQ);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      issue(5'b01010, 5'b01010, 2'b00, R_EQ, lat_sel(5, 5));
      wait_idle();

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
